ir_fir_sequencer: RTL and testbench

Time-multiplexed FIR scheduler for the cabinet impulse-response stage. It accepts one signed audio sample per handshake and stores it in a circular history of the last TAPS samples. It then drives a single shared multiply-accumulate over all TAPS coefficients from the generated IR weight vector and emits one rounded, saturated output sample. It sits between the amp/drive stage output and the codec output path.

---
 rtl/ir_pkg.sv | 21 ++
 rtl/ir_mac.sv | 62 ++++++
 rtl/ir_fir_sequencer.sv | 150 +++++++++++++++
 tb/tb_ir_fir_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared parameters and types for the cabinet impulse-response FIR stage.
package ir_pkg;

   localparam int TAPS     = 128;
   localparam int W        = 16;
   localparam int FRAC     = 15;
   localparam int TAP_BITS = $clog2(TAPS);
   // Wide enough that TAPS full-scale products can never overflow.
   localparam int ACC_W    = 2 * W + TAP_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   typedef logic signed [W-1:0]     sample_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic [TAP_BITS-1:0]     idx_t;

endpackage

// File: rtl/ir_mac.sv
// Shared multiply-accumulate datapath: signed WxW product, ACC_W accumulator
// with clear/enable, and round-and-saturate of the running sum plus the
// current product.
module ir_mac
   import ir_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                en,
   input  logic signed [W-1:0] coef,
   input  logic signed [W-1:0] samp,
   output logic signed [W-1:0] result
);

   localparam acc_t RND_HALF = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam acc_t SAT_MAX  = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam acc_t SAT_MIN  = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   // Round half-up at the Q1.15 point, then clamp into the W-bit range.
   function automatic logic signed [W-1:0] round_sat(input acc_t s);
      acc_t r;
      r = (s + RND_HALF) >>> FRAC;
      if (r > SAT_MAX) begin
         round_sat = SAT_MAX[W-1:0];
      end else if (r < SAT_MIN) begin
         round_sat = SAT_MIN[W-1:0];
      end else begin
         round_sat = r[W-1:0];
      end
   endfunction

   logic signed [2*W-1:0] prod_s;
   acc_t                  sum_s;
   acc_t                  acc_d;
   acc_t                  acc_q;

   // Product, sign-extended sum, and next accumulator value.
   always_comb begin
      prod_s = coef * samp;
      sum_s  = acc_q + {{(ACC_W-2*W){prod_s[2*W-1]}}, prod_s};
      acc_d  = acc_q;
      if (clr) begin
         acc_d = {ACC_W{1'b0}};
      end else if (en) begin
         acc_d = sum_s;
      end else begin
         acc_d = acc_q;
      end
      result = round_sat(sum_s);
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= {ACC_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/ir_fir_sequencer.sv
// Time-multiplexed FIR scheduler: owns the sample history ring, the tap
// counter and the in/out handshakes, and steps one shared MAC per cycle.
module ir_fir_sequencer
   import ir_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [TAPS-1:0][W-1:0] weights,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_data,
   input  logic                   hist_clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_data,
   output logic                   busy
);

   localparam idx_t IDX_ONE  = idx_t'(1);
   localparam idx_t IDX_ZERO = idx_t'(0);
   localparam idx_t K_LAST   = idx_t'(TAPS - 1);

   state_t         state_q, state_d;
   idx_t           head_q,  head_d;
   idx_t           k_q,     k_d;
   logic [W-1:0]   hist_q [TAPS];
   logic [W-1:0]   hist_d [TAPS];
   logic           in_ready_q,  in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_data_q,  out_data_d;
   logic           busy_q,      busy_d;

   idx_t           rd_idx_s;
   logic [W-1:0]   coef_s;
   logic [W-1:0]   samp_s;
   logic           acc_clr_s;
   logic           acc_en_s;
   logic [W-1:0]   mac_result_s;

   // Tap k pairs with the sample k positions older than the newest one;
   // the index wraps through the power-of-two width of idx_t.
   always_comb begin
      rd_idx_s = head_q - k_q;
      coef_s   = weights[k_q];
      samp_s   = hist_q[rd_idx_s];
   end

   ir_mac u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr_s),
      .en     (acc_en_s),
      .coef   (coef_s),
      .samp   (samp_s),
      .result (mac_result_s)
   );

   // Next-state, history update and registered-output computation.
   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      k_d         = k_q;
      hist_d      = hist_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      acc_clr_s   = 1'b0;
      acc_en_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (hist_clr) begin
               for (int i = 0; i < TAPS; i++) begin
                  hist_d[i] = {W{1'b0}};
               end
            end else if (in_valid) begin
               hist_d[head_q + IDX_ONE] = in_data;
               head_d     = head_q + IDX_ONE;
               k_d        = IDX_ZERO;
               acc_clr_s  = 1'b1;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = MAC;
            end else begin
               state_d = IDLE;
            end
         end
         MAC: begin
            acc_en_s = 1'b1;
            k_d      = k_q + IDX_ONE;
            if (k_q == K_LAST) begin
               out_data_d  = mac_result_s;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end else begin
               state_d = MAC;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State, counters, history and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         head_q      <= IDX_ZERO;
         k_q         <= IDX_ZERO;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= {W{1'b0}};
         busy_q      <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            hist_q[i] <= {W{1'b0}};
         end
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         k_q         <= k_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         for (int i = 0; i < TAPS; i++) begin
            hist_q[i] <= hist_d[i];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ir_fir_sequencer.sv
// Directed + randomized bench for ir_fir_sequencer with a convolution model
// kept as a plain list of the most recent TAPS samples.
module tb_ir_fir_sequencer;
   import ir_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [TAPS-1:0][W-1:0] weights;
   logic                   in_valid;
   logic                   in_ready;
   logic [W-1:0]           in_data;
   logic                   hist_clr;
   logic                   out_valid;
   logic                   out_ready;
   logic [W-1:0]           out_data;
   logic                   busy;

   int errors = 0;
   int checks = 0;
   int w_m [TAPS];
   int imp_w [TAPS];
   int hq [$];

   always #5 clk = ~clk;

   ir_fir_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .weights   (weights),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .hist_clr  (hist_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hq = {};
      for (int i = 0; i < TAPS; i++) hq.push_back(0);
   endtask

   task automatic model_push(input logic [15:0] x);
      hq.push_front(int'($signed(x)));
      void'(hq.pop_back());
   endtask

   // y = sat( round( sum_k w[k] * x[n-k] / 2^15 ) )
   function automatic logic [15:0] model_out();
      longint s;
      logic [63:0] r;
      s = 0;
      for (int k = 0; k < TAPS; k++) s += longint'(w_m[k]) * longint'(hq[k]);
      s = (s + 64'sd16384) >>> 15;
      if (s > 64'sd32767) s = 64'sd32767;
      else if (s < -64'sd32768) s = -64'sd32768;
      r = s;
      return r[15:0];
   endfunction

   task automatic apply_weights();
      int t;
      for (int k = 0; k < TAPS; k++) begin
         t = w_m[k];
         weights[k] = t[15:0];
      end
   endtask

   function automatic int rand_s16();
      int v;
      v = int'($urandom_range(0, 65535));
      if (v > 32767) v -= 65536;
      return v;
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_timeout", 32'(n < 400), 32'd1);
   endtask

   // One full transaction; delay=0 keeps out_ready high from acceptance on.
   task automatic send(input logic [15:0] x, input int delay, input bit chk_lat,
                       output logic [15:0] got);
      int n;
      logic [15:0] exp;
      wait_ready();
      out_ready = (delay == 0);
      in_valid  = 1'b1;
      in_data   = x;
      @(negedge clk);
      in_valid  = 1'b0;
      model_push(x);
      exp = model_out();
      check("busy_after_accept", 32'(busy), 32'd1);
      check("in_ready_after_accept", 32'(in_ready), 32'd0);
      n = 0;
      while (out_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (chk_lat) check("latency", n, TAPS);
      check("out_data", 32'(out_data), 32'(exp));
      check("in_ready_in_out", 32'(in_ready), 32'd0);
      got = out_data;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         check("hold_out_data", 32'(out_data), 32'(got));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_return", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   // Impulse 0x7FFF followed by zeros; each output is weight[n] within 1 LSB.
   task automatic impulse(input int n_out, input bit chk_lat);
      logic [15:0] got;
      int g;
      for (int i = 0; i < n_out; i++) begin
         send((i == 0) ? 16'h7FFF : 16'h0000, (i == 1) ? 20 : (i % 3), chk_lat && (i == 0), got);
         g = int'($signed(got));
         check("impulse_tol", 32'((g - w_m[i] <= 1) && (w_m[i] - g <= 1)), 32'd1);
         if (i == 0) check("impulse_out0", 32'(got), 32'h05C2);
         if (i == 3) check("impulse_out3", 32'(got), 32'h105B);
      end
   endtask

   task automatic pulse_clr_with_valid();
      wait_ready();
      hist_clr = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h1234;
      @(negedge clk);
      hist_clr = 1'b0;
      in_valid = 1'b0;
      check("clr_not_accepted_ready", 32'(in_ready), 32'd1);
      check("clr_not_accepted_busy", 32'(busy), 32'd0);
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      hist_clr  = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < TAPS; k++) imp_w[k] = rand_s16();
      imp_w[0] = 32'sh05C2;
      imp_w[3] = 32'sh105B;
      w_m = imp_w;
      apply_weights();
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Impulse, latency with out_ready high, 20-cycle output hold
      impulse(8, 1'b1);

      // Saturation, positive then negative
      for (int k = 0; k < TAPS; k++) w_m[k] = 32767;
      apply_weights();
      pulse_clr_with_valid();
      for (int i = 0; i < 4; i++) send(16'h7FFF, 0, 1'b0, got);
      check("sat_pos", 32'(got), 32'h7FFF);
      pulse_clr_with_valid();
      for (int i = 0; i < 4; i++) send(16'h8000, 1, 1'b0, got);
      check("sat_neg", 32'(got), 32'h8000);

      // Random weights and samples across several head wraps
      for (int k = 0; k < TAPS; k++) w_m[k] = rand_s16();
      apply_weights();
      for (int i = 0; i < 300; i++) begin
         send(16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)), 1'b1, got);
      end

      // History clear leaves no residue
      w_m = imp_w;
      apply_weights();
      for (int i = 0; i < 16; i++) send(16'h1000, 0, 1'b0, got);
      pulse_clr_with_valid();
      impulse(8, 1'b0);

      // Asynchronous reset in the middle of accumulation
      wait_ready();
      in_valid = 1'b1;
      in_data  = 16'h4000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (60) @(negedge clk);
      check("midmac_busy_before", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midmac_out_valid", 32'(out_valid), 32'd0);
      check("midmac_in_ready", 32'(in_ready), 32'd1);
      check("midmac_busy", 32'(busy), 32'd0);
      check("midmac_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      impulse(8, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
